memory_stage_8bit: RTL
======================

Name: memory_stage_8bit

Overview:
- Memory stage of the 8-bit EL3030 pipeline. It consumes the EX/MEM control and data: MR, MW, SP, SPOP, Stack_PC, Stack_Flags, address and data.
- It owns the data memory and the stack pointer, and sequences one-beat and two-beat stack transfers.
- It returns popped flags (Flags_From_Memory, MEM_Stack_Flags) to the execution unit, popped PC to fetch, and registered results to the MEM/WB buffer.

Parameters:
- DEPTH, 256, number of 8-bit memory words. Addressed by the 8-bit address modulo DEPTH.
- SP_RESET, 8'hFF, stack pointer value after reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- MR_In  input  1  memory read
- MW_In  input  1  memory write
- WB_In  input  1  write-back enable, passed through
- SP_In  input  1  push: stack write at SP
- SPOP_In  input  1  pop: stack read at SP+1
- Stack_PC_In  input  1  transfer includes PC
- Stack_Flags_In  input  1  transfer includes flags
- WB_Address_In  input  3  destination register, passed through
- Address_8bit  input  8  non-stack memory address
- Data_8bit  input  8  store data / ALU result
- PC_In  input  8  return PC to push
- Flags_In  input  4  {V,C,N,Z} to push
- Mem_Data_Out  output  8  registered load/pop data
- ALU_Data_Out  output  8  registered Data_8bit pass-through
- WB_Out  output  1  registered WB_In
- WB_Address_Out  output  3  registered WB_Address_In
- MR_Out  output  1  registered MR_In (MEM/WB mux select)
- Flags_From_Memory  output  4  popped {V,C,N,Z}
- MEM_Stack_Flags  output  1  one-cycle pulse: Flags_From_Memory valid
- PC_From_Memory  output  8  popped PC
- PC_Load  output  1  one-cycle pulse: PC_From_Memory valid
- Stall  output  1  combinational: hold EX/MEM, first beat of two-beat op
- SP_Value  output  8  current stack pointer
- Stack_Err  output  1  sticky overflow/underflow

Behaviour:
- Reset values (immediate, asynchronous):
  - SP = SP_RESET and state = IDLE.
  - Every registered output is 0. Stall is 0 once inputs are idle.
  - Memory contents are not cleared.
- Timing:
  - All inputs are sampled on the rising edge.
  - Memory is a synchronous single-port array.
  - Load/pop data and all outputs appear one cycle after the op is sampled.
- Operation decode, in priority order:
  1. SP_In & MW_In: push.
  2. SPOP_In & MR_In: pop.
  3. MW_In: store mem[Address_8bit] = Data_8bit.
  4. MR_In: load mem[Address_8bit].
- Store-over-load: non-stack MR & MW together performs the store only; Mem_Data_Out holds its previous value.
- Push: mem[SP] = value, then SP = SP-1 (mod 256).
- Pop: read mem[SP+1], then SP = SP+1 (mod 256).
- One-beat push values:
  - Stack_PC only: pushes PC_In.
  - Stack_Flags only: pushes {4'b0, Flags_In}.
  - Neither: pushes Data_8bit.
- One-beat pop results:
  - Stack_PC only: PC_From_Memory = data, PC_Load pulse.
  - Stack_Flags only: Flags_From_Memory = data[3:0], MEM_Stack_Flags pulse.
  - Neither: Mem_Data_Out = data.
- Two-beat ops (Stack_PC_In & Stack_Flags_In):
  - FSM states: IDLE, PUSH2, POP2.
  - IDLE with two-beat push:
    - Stall = 1.
    - Push PC_In at SP; go to PUSH2.
  - PUSH2:
    - Stall = 0.
    - Push {4'b0, Flags_In} at new SP; go to IDLE.
  - IDLE with two-beat pop:
    - Stall = 1.
    - Pop flags (LIFO); MEM_Stack_Flags pulses next cycle; go to POP2.
  - POP2:
    - Stall = 0.
    - Pop PC; PC_Load pulses next cycle; go to IDLE.
  - Upstream holds inputs stable while Stall = 1. In PUSH2/POP2 the FSM ignores re-decoding of those same held inputs.
  - Net effect: two-beat push moves SP by -2; two-beat pop moves SP by +2.
- Stack_Err (sticky until rst):
  - Set by a push at SP = 8'h00, which wraps to 8'hFF.
  - Set by a pop at SP = 8'hFF, which wraps to 8'h00.
  - The wrapping operation still completes.
- Pass-through: WB_Out, WB_Address_Out, ALU_Data_Out and MR_Out are registered every cycle from their inputs, including stall cycles.
- MEM_Stack_Flags and PC_Load are single-cycle pulses, never held.
- Reset mid two-beat: asynchronous return to IDLE and SP = SP_RESET. Stall drops once inputs drop. No second beat is performed.
- SP_Value always reflects the register, visible the cycle after the update.

Test Plan:
- Store 8'h5A at address 8'h10, then load 8'h10 → Mem_Data_Out = 8'h5A one cycle after the load; SP stays 8'hFF.
- After reset, one-beat push of Data_8bit = 8'h33, then one-beat pop → mem[FF] = 8'h33; SP goes FF→FE→FF; Mem_Data_Out = 8'h33.
- Two-beat push with PC_In = 8'h42, Flags_In = 4'b1010 → Stall high exactly 1 cycle; mem[FF] = 8'h42, mem[FE] = 8'h0A; SP = FD.
- Two-beat pop following that push:
  - Stall high 1 cycle.
  - MEM_Stack_Flags pulses with Flags_From_Memory = 4'b1010.
  - Next cycle PC_Load pulses with PC_From_Memory = 8'h42.
  - SP = FF.
- SP at 8'h00 then push → SP = FF, Stack_Err = 1, stays 1 across later ops until rst. Pop at SP = FF after reset → SP = 00, Stack_Err = 1.
- Assert rst during the PUSH2 cycle → SP = FF, state IDLE, PC_Load/MEM_Stack_Flags = 0; mem[FE] is not written by the flags beat.

Source files
------------

// File: rtl/memory_stage_8bit.sv
`default_nettype none
// ============================================================================
// Module  : memory_stage_8bit
// Brief   : EL3030 memory stage. Owns the data memory and the stack pointer,
//           and sequences one- and two-beat stack transfers.
// Revision: 1.0 - initial release
// ============================================================================
module memory_stage_8bit #(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] SP_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MR_In,
    input  logic       MW_In,
    input  logic       WB_In,
    input  logic       SP_In,
    input  logic       SPOP_In,
    input  logic       Stack_PC_In,
    input  logic       Stack_Flags_In,
    input  logic [2:0] WB_Address_In,
    input  logic [7:0] Address_8bit,
    input  logic [7:0] Data_8bit,
    input  logic [7:0] PC_In,
    input  logic [3:0] Flags_In,
    output logic [7:0] Mem_Data_Out,
    output logic [7:0] ALU_Data_Out,
    output logic       WB_Out,
    output logic [2:0] WB_Address_Out,
    output logic       MR_Out,
    output logic [3:0] Flags_From_Memory,
    output logic       MEM_Stack_Flags,
    output logic [7:0] PC_From_Memory,
    output logic       PC_Load,
    output logic       Stall,
    output logic [7:0] SP_Value,
    output logic       Stack_Err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH2 = 2'd1,
        POP2  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_sp;
    logic [7:0]  w_sp_next;
    logic [7:0]  r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_two;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;
    logic [AW-1:0] w_idx;
    logic [7:0]  w_rdata;
    logic        w_ld_mem;
    logic        w_ld_pc;
    logic        w_ld_flags;
    logic        w_err_set;
    logic        w_stall;

    logic [7:0]  r_mem_data;
    logic [7:0]  r_alu_data;
    logic        r_wb;
    logic [2:0]  r_wb_addr;
    logic        r_mr;
    logic [3:0]  r_flags;
    logic        r_flags_pulse;
    logic [7:0]  r_pc;
    logic        r_pc_pulse;
    logic        r_err;

    // Decode and FSM next-state. Second beats ignore the held inputs' decode.
    always_comb begin
        w_push       = SP_In & MW_In;
        w_pop        = SPOP_In & MR_In & ~w_push;
        w_two        = Stack_PC_In & Stack_Flags_In;
        w_state_next = r_state;
        w_sp_next    = r_sp;
        w_we         = 1'b0;
        w_addr       = Address_8bit;
        w_wdata      = Data_8bit;
        w_ld_mem     = 1'b0;
        w_ld_pc      = 1'b0;
        w_ld_flags   = 1'b0;
        w_err_set    = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_we      = 1'b1;
                    w_addr    = r_sp;
                    w_sp_next = r_sp - 8'd1;
                    w_err_set = (r_sp == 8'h00);
                    if (Stack_PC_In) begin
                        w_wdata = PC_In;
                    end else if (Stack_Flags_In) begin
                        w_wdata = {4'b0000, Flags_In};
                    end
                    if (w_two) begin
                        w_stall      = 1'b1;
                        w_state_next = PUSH2;
                    end
                end else if (w_pop) begin
                    w_addr    = r_sp + 8'd1;
                    w_sp_next = r_sp + 8'd1;
                    w_err_set = (r_sp == 8'hFF);
                    if (w_two) begin
                        w_ld_flags   = 1'b1;
                        w_stall      = 1'b1;
                        w_state_next = POP2;
                    end else if (Stack_PC_In) begin
                        w_ld_pc = 1'b1;
                    end else if (Stack_Flags_In) begin
                        w_ld_flags = 1'b1;
                    end else begin
                        w_ld_mem = 1'b1;
                    end
                end else if (MW_In) begin
                    w_we = 1'b1;
                end else if (MR_In) begin
                    w_ld_mem = 1'b1;
                end
            end
            PUSH2: begin
                w_we         = 1'b1;
                w_addr       = r_sp;
                w_wdata      = {4'b0000, Flags_In};
                w_sp_next    = r_sp - 8'd1;
                w_err_set    = (r_sp == 8'h00);
                w_state_next = IDLE;
            end
            POP2: begin
                w_addr       = r_sp + 8'd1;
                w_sp_next    = r_sp + 8'd1;
                w_err_set    = (r_sp == 8'hFF);
                w_ld_pc      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_idx   = AW'({1'b0, w_addr} % 9'(DEPTH));
    assign w_rdata = r_mem[w_idx];

    // Memory has no reset; writes are blocked while rst is held.
    always_ff @(posedge clk) begin
        if (w_we && !rst) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sp          <= SP_RESET;
            r_mem_data    <= 8'h00;
            r_alu_data    <= 8'h00;
            r_wb          <= 1'b0;
            r_wb_addr     <= 3'b000;
            r_mr          <= 1'b0;
            r_flags       <= 4'h0;
            r_flags_pulse <= 1'b0;
            r_pc          <= 8'h00;
            r_pc_pulse    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sp          <= w_sp_next;
            r_alu_data    <= Data_8bit;
            r_wb          <= WB_In;
            r_wb_addr     <= WB_Address_In;
            r_mr          <= MR_In;
            r_flags_pulse <= w_ld_flags;
            r_pc_pulse    <= w_ld_pc;
            if (w_ld_mem) begin
                r_mem_data <= w_rdata;
            end
            if (w_ld_flags) begin
                r_flags <= w_rdata[3:0];
            end
            if (w_ld_pc) begin
                r_pc <= w_rdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Mem_Data_Out      = r_mem_data;
    assign ALU_Data_Out      = r_alu_data;
    assign WB_Out            = r_wb;
    assign WB_Address_Out    = r_wb_addr;
    assign MR_Out            = r_mr;
    assign Flags_From_Memory = r_flags;
    assign MEM_Stack_Flags   = r_flags_pulse;
    assign PC_From_Memory    = r_pc;
    assign PC_Load           = r_pc_pulse;
    assign Stall             = w_stall;
    assign SP_Value          = r_sp;
    assign Stack_Err         = r_err;

endmodule
`default_nettype wire
